// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - UART echo endpoint: RX bytes buffered in a FIFO and replayed to TX
//
// Sits between one UART_RX and one UART_TX. Each received byte is queued and
// launched to the transmitter in arrival order. One launch is made per stored byte,
// and the next launch waits for the previous completion. Bytes that arrive while
// the FIFO is full are dropped, and a sticky flag records the loss.
//
// Optional feature macro: UART_ECHO_UPPERCASE_EN
//   When defined, ASCII a-z is sent as A-Z. The FIFO always holds raw bytes.
//
// Ports:
//   i_Clock          system clock, rising edge
//   i_Rst_L          asynchronous reset, active low
//   i_RX_DV          one-cycle strobe: i_RX_Byte valid
//   i_RX_Byte        received byte
//   i_TX_Active      UART_TX busy flag
//   i_TX_Done        UART_TX one-cycle completion strobe
//   i_Clear_Overflow clears o_Overflow (a simultaneous drop wins)
//   o_TX_DV          one-cycle launch strobe to UART_TX
//   o_TX_Byte        byte to transmit, held until the next launch
//   o_Fifo_Count     entries currently stored
//   o_Overflow       sticky: a byte was dropped because the FIFO was full
module uart_echo_responder #(
  parameter int FIFO_DEPTH      = 8,
  parameter int TURNAROUND_CLKS = 0
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_RX_DV,
  input  logic [7:0]                    i_RX_Byte,
  input  logic                          i_TX_Active,
  input  logic                          i_TX_Done,
  input  logic                          i_Clear_Overflow,
  output logic                          o_TX_DV,
  output logic [7:0]                    o_TX_Byte,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] GAP_LAST   = (TURNAROUND_CLKS > 0) ? 16'(TURNAROUND_CLKS - 1) : 16'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_ACTIVE,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_q;
  logic [15:0]     gap_q;
  logic            tx_dv_q;
  logic [7:0]      tx_byte_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW:0]     count_d;
  logic            overflow_q;

  logic            pop;
  logic            full;
  logic            push;
  logic            drop;

  function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef UART_ECHO_UPPERCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end
    return b;
`else
    return b;
`endif
  endfunction

  // The head is consumed on the same edge that registers the launch.
  assign pop  = (state_q == S_LOAD);
  assign full = (count_q == FULL_COUNT);
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push = i_RX_DV && (!full || pop);
  assign drop = i_RX_DV && full && !pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: contents are unreachable once the pointers clear.
  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_RX_Byte;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (i_Clear_Overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_dv_q <= 1'b0;
      case (state_q)
        // The idle check on i_TX_Active also covers a transmitter still
        // finishing a byte launched before our reset.
        S_IDLE: begin
          if (count_q != '0 && !i_TX_Active) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= echo_map(mem_q[rd_ptr_q]);
          state_q   <= S_WAIT_ACTIVE;
        end
        S_WAIT_ACTIVE: begin
          if (i_TX_Done) begin
            gap_q   <= '0;
            state_q <= (TURNAROUND_CLKS == 0) ? S_IDLE : S_GAP;
          end else if (i_TX_Active) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (i_TX_Done) begin
            gap_q   <= '0;
            state_q <= (TURNAROUND_CLKS == 0) ? S_IDLE : S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_TX_DV      = tx_dv_q;
  assign o_TX_Byte    = tx_byte_q;
  assign o_Fifo_Count = count_q;
  assign o_Overflow   = overflow_q;

endmodule
